// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
// State encoding plus the counter saturation limit.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    TIMEOUT
  } pm_state_e;

  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Input synchronizer with one history flop for edge detection.
// Reused for buttons, switches and slow clock sources.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Reports each measurement with a one-cycle valid and flags a lost signal.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = 18,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic level;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  pm_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_hold;

  // cnt < MAX on the increment path, and hi_cnt never exceeds cnt,
  // so both counters stop at MAX without explicit clamping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cnt    <= '0;
      hi_hold   <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!En) begin
        state   <= IDLE;
        locked  <= 1'b0;
        timeout <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (rise) begin
              cnt     <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
              hi_hold <= '0;
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period    <= cnt;
              high_time <= hi_hold;
              valid     <= 1'b1;
              locked    <= 1'b1;
              cnt       <= CNT_W'(1);
              hi_cnt    <= CNT_W'(1);
              hi_hold   <= '0;
            end else if (cnt == MAX) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
              locked  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
              if (level) begin
                hi_cnt <= hi_cnt + 1'b1;
              end
              if (fall) begin
                hi_hold <= hi_cnt;
              end
            end
          end
          TIMEOUT: begin
            if (rise) begin
              timeout <= 1'b0;
              cnt     <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
              hi_hold <= '0;
              state   <= MEASURE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
